// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width constants for the registered ripple-carry adder
package adder_pkg;
  localparam int WIDTH    = 16;
  localparam int RESULT_W = WIDTH + 1;
endpackage

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - combinational single-bit full adder cell
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: rtl/full_adder_16bit.sv
// rtl/full_adder_16bit.sv - ripple-carry adder with a registered {c_out, sum} result
module full_adder_16bit
  import adder_pkg::*;
#(
  parameter int WIDTH = adder_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH:0]   result_d;
  logic [WIDTH:0]   result_q;

  assign carry[0] = c_in;

  // Each cell takes the carry of the bit below it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1bit u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .sum   (sum_d[i]),
      .c_out (carry[i+1])
    );
  end

  assign result_d = {carry[WIDTH], sum_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign sum   = result_q[WIDTH-1:0];
  assign c_out = result_q[WIDTH];
endmodule

// File: tb/tb_full_adder_16bit.sv
// tb/tb_full_adder_16bit.sv - scoreboard bench with directed vectors for full_adder_16bit
module tb_full_adder_16bit;
  import adder_pkg::*;

  logic                clk;
  logic                rst;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                c_in;
  logic [WIDTH-1:0]    sum;
  logic                c_out;

  logic [RESULT_W-1:0] exp_q[$];
  int                  checks;
  int                  errors;

  full_adder_16bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one result per clock, checked 1 time unit after the edge.
  initial begin
    logic [RESULT_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({c_out, sum} !== e) begin
          errors++;
          $display("FAIL result: got c_out=%0b sum=0x%04h, expected c_out=%0b sum=0x%04h",
                   c_out, sum, e[RESULT_W-1], e[WIDTH-1:0]);
        end
      end
    end
  end

  // Applies operands for the next edge and records the hand-computed result.
  task automatic issue(input logic r, input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, input logic eco, input logic [15:0] esum);
    rst  = r;
    a    = va;
    b    = vb;
    c_in = vc;
    exp_q.push_back({eco, esum});
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; a = '0; b = '0; c_in = 1'b0;

    issue(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
    issue(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002);
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000);
    issue(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556);
    issue(1'b0, 16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01);
    issue(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001);
    issue(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF);
    issue(1'b0, 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000);
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000);
    issue(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000);
    issue(1'b0, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'hFFFF);
    issue(1'b0, 16'h5555, 16'hAAAA, 1'b1, 1'b1, 16'h0000);
    issue(1'b0, 16'h00FF, 16'hFF01, 1'b0, 1'b1, 16'h0000);
    issue(1'b0, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 16'h0000);
    issue(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345);
    issue(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000);
    issue(1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003);
    issue(1'b0, 16'h8001, 16'h7FFF, 1'b1, 1'b1, 16'h0001);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_adder_16bit.md
FULL_ADDER_16BIT -- requirements
Module: full_adder_16bit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand and sum width in bits; every requirement below uses WIDTH=16.
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-003 The block SHALL have a port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have a port a, input, 16 bits: addend A, unsigned.
REQ-005 The block SHALL have a port b, input, 16 bits: addend B, unsigned.
REQ-006 The block SHALL have a port c_in, input, 1 bit: carry into bit 0.
REQ-007 The block SHALL have a port sum, output, 16 bits: registered low 16 bits of a+b+c_in.
REQ-008 The block SHALL have a port c_out, output, 1 bit: registered carry out of bit 15.

Function
REQ-009 At each rising clk edge with rst low, the block SHALL compute {c_out, sum} = a + b + c_in as a 17-bit unsigned result from the a, b and c_in values present before that edge.
REQ-010 Latency SHALL be exactly one clock: the result appears on sum/c_out after the sampling edge and holds until the next edge.
REQ-011 There SHALL be no handshake: a new operation is accepted every cycle, with throughput of one addition per clock.
REQ-012 Arithmetic SHALL be modulo 2^16 on sum. On wrap-around (result >= 0x10000), c_out SHALL be 1 and sum SHALL equal the result minus 0x10000.
REQ-013 Maximum case: a=0xFFFF, b=0xFFFF, c_in=1 SHALL give sum=0xFFFF, c_out=1.
REQ-014 The carry chain SHALL be ripple-carry: bit i receives the carry of bit i-1, and bit 0 receives c_in.
REQ-015 sum and c_out SHALL be driven only by registers, with no combinational path from any input to any output.
REQ-016 Inputs that change between edges SHALL have no effect on the outputs until the next rising edge.

Reset
REQ-017 When rst is high at a rising clk edge, sum SHALL become 0x0000 and c_out SHALL become 0, regardless of a, b and c_in.
REQ-018 If rst is asserted in the same cycle as a new operation, reset SHALL take priority and that operation's result is discarded.
REQ-019 On the first rising edge with rst low after reset, the block SHALL register the current a+b+c_in normally, with no extra bubble cycle.
REQ-020 Outputs are undefined before the first reset edge; benches SHALL apply reset before checking results.

Structure
REQ-021 WIDTH and a 17-bit result-width constant SHALL be defined in a shared package, adder_pkg. No typedefs are required.
REQ-022 The block SHALL use one sub-module, full_adder_1bit, with ports a, b, c_in, sum and c_out, all 1 bit and purely combinational. It computes sum = a xor b xor c_in and c_out = majority(a, b, c_in).
REQ-023 full_adder_16bit SHALL instantiate 16 full_adder_1bit cells in a generate loop that forms the ripple chain, followed by a 17-bit output register.
REQ-024 The implementation SHALL contain no latches, no asynchronous logic and no multi-cycle paths.

Verification
REQ-025 A bench SHALL cover these directed scenarios and check results one clock after each input is applied:
- a=0x0001, b=0x0001, c_in=0 -> sum=0x0002, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1 (wrap-around).
- a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, c_out=0.
- a=0xABCD, b=0x1234, c_in=0 -> sum=0xBE01, c_out=0; then a=0x0000, b=0x0000, c_in=1 -> sum=0x0001, c_out=0.
- rst=1 while a=0xFFFF, b=0xFFFF, c_in=1 -> sum=0x0000, c_out=0. Deasserting rst with the same inputs -> sum=0xFFFF, c_out=1 after one edge.
- Back-to-back new operands every cycle -> each result appears exactly one cycle after its operands, with no dropped operation.
